// File: rtl/ulpi_reg_ctrl_pkg.sv
// Shared definitions for the ULPI register-access sequencer.
//   - TX CMD prefixes for immediate register write/read
//   - NOOP bus value driven whenever the link is not transmitting
//   - FSM state encoding and the latched request record
package ulpi_reg_ctrl_pkg;

  localparam logic [1:0] TxcmdRegW = 2'b10;
  localparam logic [1:0] TxcmdRegR = 2'b11;
  localparam logic [7:0] Noop      = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StTxcmd,
    StRetry,
    StWdata,
    StWstp,
    StRturn,
    StRdata,
    StAbort
  } state_e;

  typedef struct packed {
    logic       rw;     // 1 = read, 0 = write
    logic [5:0] addr;
    logic [7:0] wdata;
  } req_t;

  // TX CMD byte for an immediate register access.
  function automatic logic [7:0] txcmd_byte(input req_t r);
    return {(r.rw ? TxcmdRegR : TxcmdRegW), r.addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ULPI register transaction sequencer between the sniffer control logic and a USB3300 PHY.
// Turns a one-shot read/write request into the TX CMD / data / STP sequence, handles DIR
// turnaround, PHY abort (DIR before NXT) and timeout, and captures RX CMD bytes while idle.
//
// Ports
//   clk_i            ULPI 60 MHz clock from the PHY
//   rst_i            synchronous active-high reset
//   req_valid_i      request, held until accepted (req_valid_i & req_ready_o)
//   req_ready_o      high in idle while DIR is low now and was low last cycle
//   req_rw_i         1 = read, 0 = write
//   req_addr_i       immediate register address
//   req_wdata_i      write data
//   done_o           one-cycle pulse at transaction end
//   err_o            qualifies done_o: 1 = timeout
//   rd_data_o        read result, valid from done_o, held until the next read
//   rxcmd_o          last RX CMD byte
//   rxcmd_valid_o    one-cycle pulse when rxcmd_o updates
//   dir_i, nxt_i     ULPI DIR / NXT
//   data_i           ULPI data from the PHY
//   data_o           ULPI data to the PHY (NOOP when not transmitting)
//   stp_o            ULPI STP
module ulpi_reg_ctrl
  import ulpi_reg_ctrl_pkg::*;
#(
  parameter int unsigned Timeout = 64,
  parameter int unsigned CntW    = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rd_data_o,
  output logic [7:0] rxcmd_o,
  output logic       rxcmd_valid_o,
  input  logic       dir_i,
  input  logic       nxt_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       stp_o
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(Timeout - 1);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      rxcmd_q, rxcmd_d;
  logic            rxcmd_valid_q, rxcmd_valid_d;
  logic [7:0]      data_o_q, data_o_d;
  logic            stp_q, stp_d;

  logic accept;
  logic timeout;
  logic waiting;

  // Ready only once the bus has been ours for a full cycle, so the turnaround after a
  // PHY-driven phase is never overlapped by a new TX CMD.
  assign req_ready_o = (state_q == StIdle) && !dir_i && !dir_q && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign timeout     = (cnt_q == TimeoutCnt);
  assign waiting     = state_q inside {StTxcmd, StRetry, StWdata, StRturn};

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rd_data_d     = rd_data_q;
    rxcmd_d       = rxcmd_q;
    rxcmd_valid_d = 1'b0;

    if (waiting) begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          req_d   = '{rw: req_rw_i, addr: req_addr_i, wdata: req_wdata_i};
          cnt_d   = '0;
          state_d = StTxcmd;
        end else if (dir_i && dir_q && !nxt_i) begin
          // PHY-driven idle bus with NXT low carries an RX CMD; dir_q excludes turnaround.
          rxcmd_d       = data_i;
          rxcmd_valid_d = 1'b1;
        end
      end
      StTxcmd: begin
        if (timeout) begin
          state_d = StAbort;
        end else if (dir_i) begin
          // DIR before NXT: PHY took the bus, retry once it hands it back.
          state_d = StRetry;
        end else if (nxt_i) begin
          state_d = req_q.rw ? StRturn : StWdata;
        end
      end
      StRetry: begin
        if (timeout) begin
          state_d = StAbort;
        end else if (!dir_i && !dir_q) begin
          state_d = StTxcmd;
        end
      end
      StWdata: begin
        if (timeout) begin
          state_d = StAbort;
        end else if (nxt_i) begin
          state_d = StWstp;
          done_d  = 1'b1;
        end
      end
      StWstp: begin
        state_d = StIdle;
      end
      StRturn: begin
        if (timeout) begin
          state_d = StAbort;
        end else if (dir_i) begin
          // This DIR-high cycle is the turnaround; data follows in the next cycle.
          state_d = StRdata;
        end
      end
      StRdata: begin
        rd_data_d = data_i;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StAbort) begin
      done_d = 1'b1;
      err_d  = 1'b1;
    end
  end

  // Bus outputs registered from the next state so they line up with the state they belong to.
  always_comb begin
    data_o_d = Noop;
    unique case (state_d)
      StTxcmd: data_o_d = txcmd_byte(req_d);
      StWdata: data_o_d = req_d.wdata;
      default: data_o_d = Noop;
    endcase
    stp_d = (state_d == StWstp) || (state_d == StAbort);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      req_q         <= '0;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
      rxcmd_q       <= '0;
      rxcmd_valid_q <= 1'b0;
      data_o_q      <= Noop;
      stp_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_i;
      done_q        <= done_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      rxcmd_q       <= rxcmd_d;
      rxcmd_valid_q <= rxcmd_valid_d;
      data_o_q      <= data_o_d;
      stp_q         <= stp_d;
    end
  end

  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rd_data_o     = rd_data_q;
  assign rxcmd_o       = rxcmd_q;
  assign rxcmd_valid_o = rxcmd_valid_q;
  assign data_o        = data_o_q;
  assign stp_o         = stp_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl: write, read, PHY abort/retry, timeout, RX CMD capture,
// and reset in the middle of a transaction. Outputs are sampled 1 time unit after posedge.
module tb_ulpi_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       done;
  logic       err;
  logic [7:0] rd_data;
  logic [7:0] rxcmd;
  logic       rxcmd_valid;
  logic       dir;
  logic       nxt;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       stp;

  int n_cmp;
  int n_bad;
  int cyc;

  ulpi_reg_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rw_i      (req_rw),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .done_o        (done),
    .err_o         (err),
    .rd_data_o     (rd_data),
    .rxcmd_o       (rxcmd),
    .rxcmd_valid_o (rxcmd_valid),
    .dir_i         (dir),
    .nxt_i         (nxt),
    .data_i        (data_in),
    .data_o        (data_out),
    .stp_o         (stp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [7:0] d, input logic s, input logic dn,
                     input logic e);
    chk({tag, " data_o"}, data_out, d);
    chk({tag, " stp"}, {7'b0, stp}, {7'b0, s});
    chk({tag, " done"}, {7'b0, done}, {7'b0, dn});
    if (dn) chk({tag, " err"}, {7'b0, err}, {7'b0, e});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    dir = 1'b0; nxt = 1'b0; data_in = 8'h00;
    tick();
    tick();

    // Reset state
    bus("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst req_ready", {7'b0, req_ready}, 8'h00);
    chk("rst rd_data", rd_data, 8'h00);
    chk("rst rxcmd", rxcmd, 8'h00);
    chk("rst rxcmd_valid", {7'b0, rxcmd_valid}, 8'h00);
    rst = 1'b0;
    tick();
    chk("idle req_ready", {7'b0, req_ready}, 8'h01);

    // 1: write 0x48 to 0x04, NXT one cycle after TX CMD appears
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h04; req_wdata = 8'h48;
    #1;
    chk("w1 ready", {7'b0, req_ready}, 8'h01);
    tick();
    req_valid = 1'b0;
    bus("w1 txcmd", 8'h84, 1'b0, 1'b0, 1'b0);
    tick();
    bus("w1 txcmd hold", 8'h84, 1'b0, 1'b0, 1'b0);
    nxt = 1'b1;
    tick();
    bus("w1 wdata", 8'h48, 1'b0, 1'b0, 1'b0);
    tick();
    bus("w1 stp", 8'h00, 1'b1, 1'b1, 1'b0);
    nxt = 1'b0;
    tick();
    bus("w1 end", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("w1 ready after", {7'b0, req_ready}, 8'h01);

    // 2: read 0x0A, PHY returns 0x55
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'h0A;
    tick();
    req_valid = 1'b0;
    bus("r2 txcmd", 8'hCA, 1'b0, 1'b0, 1'b0);
    nxt = 1'b1;
    tick();
    bus("r2 rturn", 8'h00, 1'b0, 1'b0, 1'b0);
    nxt = 1'b0; dir = 1'b1;
    tick();
    bus("r2 rdata", 8'h00, 1'b0, 1'b0, 1'b0);
    data_in = 8'h55;
    tick();
    chk("r2 done", {7'b0, done}, 8'h01);
    chk("r2 err", {7'b0, err}, 8'h00);
    chk("r2 rd_data", rd_data, 8'h55);
    chk("r2 no rxcmd", {7'b0, rxcmd_valid}, 8'h00);
    dir = 1'b0; data_in = 8'h00;
    #1;
    chk("r2 ready turnaround", {7'b0, req_ready}, 8'h00);
    tick();
    chk("r2 done pulse", {7'b0, done}, 8'h00);
    chk("r2 ready", {7'b0, req_ready}, 8'h01);
    chk("r2 rd_data hold", rd_data, 8'h55);

    // 3: PHY abort during TX CMD, DIR high for 5 cycles; request inputs change meanwhile
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h04; req_wdata = 8'h11;
    tick();
    req_valid = 1'b0; req_addr = 6'h3F; req_wdata = 8'hFF;
    bus("a3 txcmd", 8'h84, 1'b0, 1'b0, 1'b0);
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus("a3 retry", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    dir = 1'b0;
    tick();
    bus("a3 retry turn", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    bus("a3 reissue", 8'h84, 1'b0, 1'b0, 1'b0);
    nxt = 1'b1;
    tick();
    bus("a3 wdata", 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    bus("a3 stp", 8'h00, 1'b1, 1'b1, 1'b0);
    nxt = 1'b0;
    tick();
    bus("a3 end", 8'h00, 1'b0, 1'b0, 1'b0);

    // 4: NXT never comes -> timeout abort 65 cycles after accept
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h04; req_wdata = 8'h22;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t4 latency", 8'(cyc), 8'd65);
    bus("t4 abort", 8'h00, 1'b1, 1'b1, 1'b1);
    chk("t4 rd_data kept", rd_data, 8'h55);
    tick();
    bus("t4 end", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4 ready", {7'b0, req_ready}, 8'h01);

    // 5: RX CMD on idle bus, DIR high 3 cycles; first DIR cycle is turnaround
    dir = 1'b1; data_in = 8'h4C;
    #1;
    chk("x5 ready dir", {7'b0, req_ready}, 8'h00);
    tick();
    chk("x5 v1", {7'b0, rxcmd_valid}, 8'h00);
    tick();
    chk("x5 v2", {7'b0, rxcmd_valid}, 8'h01);
    chk("x5 rxcmd", rxcmd, 8'h4C);
    tick();
    chk("x5 v3", {7'b0, rxcmd_valid}, 8'h01);
    dir = 1'b0; data_in = 8'h00;
    tick();
    chk("x5 v4", {7'b0, rxcmd_valid}, 8'h00);
    chk("x5 rxcmd hold", rxcmd, 8'h4C);
    chk("x5 no done", {7'b0, done}, 8'h00);

    // 6: reset while in WDATA, then a clean write
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h04; req_wdata = 8'h66;
    tick();
    req_valid = 1'b0;
    nxt = 1'b1;
    tick();
    bus("s6 wdata", 8'h66, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; nxt = 1'b0;
    tick();
    bus("s6 rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("s6 rst ready", {7'b0, req_ready}, 8'h00);
    chk("s6 rst rd_data", rd_data, 8'h00);
    rst = 1'b0;
    tick();
    bus("s6 post", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("s6 ready", {7'b0, req_ready}, 8'h01);
    req_valid = 1'b1; req_addr = 6'h05; req_wdata = 8'h99;
    tick();
    req_valid = 1'b0;
    bus("s6 txcmd", 8'h85, 1'b0, 1'b0, 1'b0);
    nxt = 1'b1;
    tick();
    bus("s6 wdata2", 8'h99, 1'b0, 1'b0, 1'b0);
    tick();
    bus("s6 stp", 8'h00, 1'b1, 1'b1, 1'b0);
    nxt = 1'b0;
    tick();
    bus("s6 end", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
